// File: rtl/multi_gate_unit.sv
// multi_gate_unit: per-bit logic gate unit with a 2-entry in-order result queue,
// a saturating accepted-operation counter and a sticky illegal-mode flag.
// Optional feature: define MULTI_GATE_REDUCE_EN to add the f_red port, which is the
// XOR-reduction of the head result.
module multi_gate_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [CNT_W-1:0] op_count,
`ifdef MULTI_GATE_REDUCE_EN
  output logic             f_red,
`endif
  output logic             err
);

  typedef enum logic [2:0] {
    ModeAnd     = 3'd0,
    ModeNand    = 3'd1,
    ModeOr      = 3'd2,
    ModeNor     = 3'd3,
    ModeXor     = 3'd4,
    ModeXnor    = 3'd5,
    ModeNotA    = 3'd6,
    ModeIllegal = 3'd7
  } mode_e;

  localparam logic [1:0] Depth = 2'd2;

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] gate_res;
  logic             illegal;
  logic             push;
  logic             pop;

  // Gate evaluation of the presented operand set; illegal mode yields zeros.
  always_comb begin
    gate_res = '0;
    illegal  = 1'b0;
    unique case (mode_e'(mode))
      ModeAnd:     gate_res = a & b;
      ModeNand:    gate_res = ~(a & b);
      ModeOr:      gate_res = a | b;
      ModeNor:     gate_res = ~(a | b);
      ModeXor:     gate_res = a ^ b;
      ModeXnor:    gate_res = ~(a ^ b);
      ModeNotA:    gate_res = ~a;
      ModeIllegal: illegal  = 1'b1;
      default:     gate_res = '0;
    endcase
  end

  // Handshakes; in_ready depends only on stored occupancy, never on out_ready.
  always_comb begin
    in_ready  = (count_q != Depth);
    out_valid = (count_q != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Queue, counter and error next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) begin
      mem_d[wr_ptr_q] = gate_res;
      wr_ptr_d        = ~wr_ptr_q;
      // Saturate rather than wrap.
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (illegal) begin
        err_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every queued result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Head result is forced to zero whenever the queue is empty.
  always_comb begin
    f        = out_valid ? mem_q[rd_ptr_q] : '0;
    op_count = cnt_q;
    err      = err_q;
  end

`ifdef MULTI_GATE_REDUCE_EN
  // Parity of the head result; f is already zero while empty.
  always_comb begin
    f_red = ^f;
  end
`endif

endmodule
